// File: rtl/gpio_pad_ctrl_pkg.sv
// Shared constants for the GPIO pad controller: register map and default sizing.
package gpio_pad_ctrl_pkg;

  localparam int DEFAULT_WIDTH         = 8;
  localparam int DEFAULT_FILTER_CYCLES = 4;

  localparam logic [2:0] ADDR_OUT     = 3'd0;
  localparam logic [2:0] ADDR_OE      = 3'd1;
  localparam logic [2:0] ADDR_IN      = 3'd2;
  localparam logic [2:0] ADDR_RISE_IE = 3'd3;
  localparam logic [2:0] ADDR_FALL_IE = 3'd4;
  localparam logic [2:0] ADDR_PEND    = 3'd5;

endpackage

// File: rtl/gpio_pin_filter.sv
// One pad input: 2-flop synchronizer, glitch filter and registered edge pulses.
// rise/fall are high for one cycle, the cycle in which filt first shows its new value.
module gpio_pin_filter
  import gpio_pad_ctrl_pkg::*;
#(
  parameter int FILTER_CYCLES = DEFAULT_FILTER_CYCLES
) (
  input  logic clk,
  input  logic reset_n,
  input  logic pin,
  output logic filt,
  output logic rise,
  output logic fall
);

  localparam logic [7:0] CNT_LAST = 8'(FILTER_CYCLES - 1);

  logic       sync_meta_reg;
  logic       sync_reg;
  logic       filt_reg;
  logic [7:0] cnt_reg;
  logic       rise_reg;
  logic       fall_reg;
  logic       accept;

  // The synchronized value has differed for FILTER_CYCLES consecutive cycles
  assign accept = (sync_reg != filt_reg) && (cnt_reg == CNT_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_meta_reg <= 1'b0;
      sync_reg      <= 1'b0;
    end else begin
      sync_meta_reg <= pin;
      sync_reg      <= sync_meta_reg;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      filt_reg <= 1'b0;
      cnt_reg  <= 8'd0;
      rise_reg <= 1'b0;
      fall_reg <= 1'b0;
    end else begin
      rise_reg <= accept & sync_reg;
      fall_reg <= accept & ~sync_reg;
      if (sync_reg == filt_reg) begin
        cnt_reg <= 8'd0;
      end else if (accept) begin
        filt_reg <= sync_reg;
        cnt_reg  <= 8'd0;
      end else begin
        cnt_reg <= cnt_reg + 8'd1;
      end
    end
  end

  assign filt = filt_reg;
  assign rise = rise_reg;
  assign fall = fall_reg;

endmodule

// File: rtl/gpio_pad_ctrl.sv
// GPIO pad controller: register file, filtered pad inputs, edge-pending bits and level irq.
module gpio_pad_ctrl
  import gpio_pad_ctrl_pkg::*;
#(
  parameter int WIDTH         = DEFAULT_WIDTH,
  parameter int FILTER_CYCLES = DEFAULT_FILTER_CYCLES
) (
  input  logic             clk,
  input  logic             reset_n,
  output logic [WIDTH-1:0] c2p,
  output logic [WIDTH-1:0] c2p_en,
  input  logic [WIDTH-1:0] p2c,
  input  logic             wr_en,
  input  logic             rd_en,
  input  logic [2:0]       addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             irq
);

  logic [WIDTH-1:0] out_reg;
  logic [WIDTH-1:0] oe_reg;
  logic [WIDTH-1:0] rise_ie_reg;
  logic [WIDTH-1:0] fall_ie_reg;
  logic [WIDTH-1:0] pend_reg;
  logic [WIDTH-1:0] pend_next;
  logic [WIDTH-1:0] pend_clr;
  logic [WIDTH-1:0] rdata_reg;
  logic [WIDTH-1:0] read_mux;
  logic             irq_reg;
  logic [WIDTH-1:0] filt;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_pin
    gpio_pin_filter #(
      .FILTER_CYCLES(FILTER_CYCLES)
    ) u_filter (
      .clk    (clk),
      .reset_n(reset_n),
      .pin    (p2c[gi]),
      .filt   (filt[gi]),
      .rise   (rise[gi]),
      .fall   (fall[gi])
    );
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_reg     <= '0;
      oe_reg      <= '0;
      rise_ie_reg <= '0;
      fall_ie_reg <= '0;
    end else if (wr_en) begin
      case (addr)
        ADDR_OUT:     out_reg     <= wdata;
        ADDR_OE:      oe_reg      <= wdata;
        ADDR_RISE_IE: rise_ie_reg <= wdata;
        ADDR_FALL_IE: fall_ie_reg <= wdata;
        default: ;
      endcase
    end
  end

  // A new edge in the same cycle as its write-1-to-clear keeps the bit set
  assign pend_clr  = (wr_en && addr == ADDR_PEND) ? wdata : '0;
  assign pend_next = (pend_reg & ~pend_clr) | (rise & rise_ie_reg) | (fall & fall_ie_reg);

  always_comb begin
    read_mux = '0;
    case (addr)
      ADDR_OUT:     read_mux = out_reg;
      ADDR_OE:      read_mux = oe_reg;
      ADDR_IN:      read_mux = filt;
      ADDR_RISE_IE: read_mux = rise_ie_reg;
      ADDR_FALL_IE: read_mux = fall_ie_reg;
      ADDR_PEND:    read_mux = pend_reg;
      default:      read_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend_reg  <= '0;
      irq_reg   <= 1'b0;
      rdata_reg <= '0;
    end else begin
      pend_reg <= pend_next;
      irq_reg  <= |pend_reg;
      if (rd_en) begin
        rdata_reg <= read_mux;
      end
    end
  end

  assign c2p    = out_reg;
  assign c2p_en = oe_reg;
  assign rdata  = rdata_reg;
  assign irq    = irq_reg;

endmodule
